// File: rtl/stopwatch_disp_mux.sv
`default_nettype none
// ============================================================================
// Module   : stopwatch_disp_mux
// Purpose  : Scans the three BCD stopwatch digits onto a 4-digit
//            common-anode 7-segment display. The decimal point sits after
//            the seconds digit and the tens digit is blanked when zero.
//            A lap edge freezes the shown time and puts an 'L' on the
//            leftmost digit; the next lap edge returns to live time.
// Ports    : clk          - system clock, rising edge
//            reset        - synchronous, active-high reset
//            d2, d1, d0   - BCD tens-of-seconds / seconds / tenths
//            lap          - debounced lap level; only its rising edge acts
//            an[3:0]      - digit anodes, active-low, an[0] = rightmost
//            sseg[7:0]    - segments, active-low, {dp,g,f,e,d,c,b,a}
// Params   : N            - refresh counter width (N >= 2); the top two
//                           bits select the displayed position
// Revision : 1.0 - initial release
// ============================================================================
module stopwatch_disp_mux #(
  parameter int N = 18
) (
  input  logic       clk,
  input  logic       reset,
  input  logic [3:0] d2,
  input  logic [3:0] d1,
  input  logic [3:0] d0,
  input  logic       lap,
  output logic [3:0] an,
  output logic [7:0] sseg
);

  typedef enum logic [0:0] {
    ST_LIVE   = 1'b0,
    ST_FROZEN = 1'b1
  } state_t;

  localparam logic [6:0] SEG_DASH  = 7'b0111111;
  localparam logic [6:0] SEG_L     = 7'b1000111;
  localparam logic [6:0] SEG_BLANK = 7'b1111111;

  state_t         state_q, state_d;
  logic [N-1:0]   cnt_q, cnt_d;
  logic           lap_q;
  logic [3:0]     h2_q, h1_q, h0_q;
  logic [3:0]     h2_d, h1_d, h0_d;
  logic [3:0]     an_q, an_d;
  logic [7:0]     sseg_q, sseg_d;

  logic           lap_edge;
  logic [1:0]     pos;
  logic [3:0]     src2, src1, src0;
  logic [6:0]     seg;
  logic           dp_n;

  // Active-low g..a pattern for a BCD value; 10-15 render as '-'.
  function automatic logic [6:0] bcd_to_seg(input logic [3:0] v);
    logic [6:0] s;
    case (v)
      4'd0:    s = 7'b1000000;
      4'd1:    s = 7'b1111001;
      4'd2:    s = 7'b0100100;
      4'd3:    s = 7'b0110000;
      4'd4:    s = 7'b0011001;
      4'd5:    s = 7'b0010010;
      4'd6:    s = 7'b0000010;
      4'd7:    s = 7'b1111000;
      4'd8:    s = 7'b0000000;
      4'd9:    s = 7'b0010000;
      default: s = SEG_DASH;
    endcase
    return s;
  endfunction

  // Lap edge only; holding lap high yields a single event.
  assign lap_edge = lap & ~lap_q;

  // Freeze/unfreeze state and hold registers.
  always_comb begin
    state_d = state_q;
    h2_d    = h2_q;
    h1_d    = h1_q;
    h0_d    = h0_q;
    case (state_q)
      ST_LIVE: begin
        if (lap_edge) begin
          state_d = ST_FROZEN;
          h2_d    = d2;
          h1_d    = d1;
          h0_d    = d0;
        end
      end
      ST_FROZEN: begin
        if (lap_edge) begin
          state_d = ST_LIVE;
        end
      end
      default: state_d = ST_LIVE;
    endcase
  end

  // Scan position decode; registered below so outputs lag by one cycle.
  always_comb begin
    cnt_d = cnt_q + N'(1);
    pos   = cnt_q[N-1:N-2];

    src2 = (state_q == ST_FROZEN) ? h2_q : d2;
    src1 = (state_q == ST_FROZEN) ? h1_q : d1;
    src0 = (state_q == ST_FROZEN) ? h0_q : d0;

    seg  = SEG_BLANK;
    dp_n = 1'b1;
    case (pos)
      2'd0: seg = bcd_to_seg(src0);
      2'd1: begin
        seg  = bcd_to_seg(src1);
        dp_n = 1'b0;
      end
      2'd2: seg = (src2 == 4'd0) ? SEG_BLANK : bcd_to_seg(src2);
      2'd3: seg = (state_q == ST_FROZEN) ? SEG_L : SEG_BLANK;
      default: seg = SEG_BLANK;
    endcase

    // A blanked position still has its anode driven.
    an_d   = ~(4'b0001 << pos);
    sseg_d = {dp_n, seg};
  end

  always_ff @(posedge clk) begin
    // lap_q samples even during reset so a lap held through release
    // does not register as an edge.
    lap_q <= lap;
    if (reset) begin
      state_q <= ST_LIVE;
      cnt_q   <= '0;
      h2_q    <= 4'd0;
      h1_q    <= 4'd0;
      h0_q    <= 4'd0;
      an_q    <= 4'b1111;
      sseg_q  <= 8'hFF;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      h2_q    <= h2_d;
      h1_q    <= h1_d;
      h0_q    <= h0_d;
      an_q    <= an_d;
      sseg_q  <= sseg_d;
    end
  end

  assign an   = an_q;
  assign sseg = sseg_q;

endmodule
`default_nettype wire

// File: tb/tb_stopwatch_disp_mux.sv
`default_nettype none
// ============================================================================
// Module   : tb_stopwatch_disp_mux
// Purpose  : Directed self-checking bench for stopwatch_disp_mux with N=4
//            (4 cycles per position, 16-cycle scan).
// Revision : 1.0 - initial release
// ============================================================================
module tb_stopwatch_disp_mux;

  logic       clk;
  logic       reset;
  logic [3:0] d2, d1, d0;
  logic       lap;
  logic [3:0] an;
  logic [7:0] sseg;

  int checks = 0;
  int errors = 0;
  int k      = 0;   // ticks since reset release

  stopwatch_disp_mux #(.N(4)) dut (
    .clk  (clk),
    .reset(reset),
    .d2   (d2),
    .d1   (d1),
    .d0   (d0),
    .lap  (lap),
    .an   (an),
    .sseg (sseg)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic tick();
    @(posedge clk);
    #1;
    k++;
  endtask

  task automatic check(input string tag, input logic [11:0] obs, input logic [11:0] exp);
    checks++;
    assert (obs === exp)
    else begin
      errors++;
      $error("FAIL %s: observed %h expected %h (tick %0d)", tag, obs, exp, k);
    end
  endtask

  // Output after tick k reflects counter value k-1.
  function automatic int cur_pos();
    return ((k - 1) / 4) % 4;
  endfunction

  function automatic logic [3:0] exp_an(input int p);
    case (p)
      0: return 4'b1110;
      1: return 4'b1101;
      2: return 4'b1011;
      default: return 4'b0111;
    endcase
  endfunction

  function automatic logic [7:0] pick(input int p, input logic [7:0] e0, input logic [7:0] e1,
                                      input logic [7:0] e2, input logic [7:0] e3);
    case (p)
      0: return e0;
      1: return e1;
      2: return e2;
      default: return e3;
    endcase
  endfunction

  task automatic check_now(input string tag, input logic [7:0] e0, input logic [7:0] e1,
                           input logic [7:0] e2, input logic [7:0] e3);
    int p;
    p = cur_pos();
    check(tag, {an, sseg}, {exp_an(p), pick(p, e0, e1, e2, e3)});
  endtask

  task automatic scan(input string tag, input int n, input logic [7:0] e0, input logic [7:0] e1,
                      input logic [7:0] e2, input logic [7:0] e3);
    for (int i = 0; i < n; i++) begin
      tick();
      check_now(tag, e0, e1, e2, e3);
    end
  endtask

  task automatic do_reset();
    reset = 1'b1;
    tick();
    tick();
    reset = 1'b0;
    k = 0;
  endtask

  initial begin
    reset = 1'b1;
    lap   = 1'b0;
    d2 = 4'd1; d1 = 4'd2; d0 = 4'd3;

    // Reset, then dark for the first cycle after release.
    do_reset();
    check("reset_dark", {an, sseg}, {4'b1111, 8'hFF});

    // Live 1/2/3 over a full scan plus wrap into position 0 again.
    scan("live_123", 20, 8'hB0, 8'h24, 8'hF9, 8'hFF);

    // All zeros: tens blanked, seconds shows '0' with dp.
    d2 = 4'd0; d1 = 4'd0; d0 = 4'd0;
    scan("live_000", 16, 8'hC0, 8'h40, 8'hFF, 8'hFF);

    // Lap pulse with 4/5/6, then inputs move to 7/8/9.
    d2 = 4'd4; d1 = 4'd5; d0 = 4'd6;
    lap = 1'b1;
    tick();
    check_now("lap1_edge_cycle", 8'h82, 8'h12, 8'h99, 8'hFF);
    lap = 1'b0;
    d2 = 4'd7; d1 = 4'd8; d0 = 4'd9;
    scan("frozen_456", 16, 8'h82, 8'h12, 8'h99, 8'hC7);

    // Second lap pulse: held view persists one more cycle, then live 7/8/9.
    lap = 1'b1;
    tick();
    check_now("lap2_edge_cycle", 8'h82, 8'h12, 8'h99, 8'hC7);
    lap = 1'b0;
    scan("live_789", 16, 8'h90, 8'h00, 8'hF8, 8'hFF);

    // Lap held for 20 cycles: a single freeze of 7/8/9.
    lap = 1'b1;
    tick();
    d2 = 4'd0; d1 = 4'd0; d0 = 4'd0;
    scan("lap_held", 16, 8'h90, 8'h00, 8'hF8, 8'hC7);
    tick(); tick(); tick();
    lap = 1'b0;
    scan("lap_released", 16, 8'h90, 8'h00, 8'hF8, 8'hC7);

    // Unfreeze, then a non-BCD tenths value shows '-'.
    lap = 1'b1;
    tick();
    lap = 1'b0;
    d2 = 4'd3; d1 = 4'd0; d0 = 4'hC;
    scan("dash", 16, 8'hBF, 8'h40, 8'hB0, 8'hFF);

    // Freeze, then reset with lap held high across release.
    lap = 1'b1;
    tick();
    lap = 1'b0;
    tick();
    check_now("frozen_pre_reset", 8'hBF, 8'h40, 8'hB0, 8'hC7);
    lap = 1'b1;
    d2 = 4'd1; d1 = 4'd2; d0 = 4'd3;
    do_reset();
    check("reset2_dark", {an, sseg}, {4'b1111, 8'hFF});
    scan("post_reset_live", 16, 8'hB0, 8'h24, 8'hF9, 8'hFF);

    // Lap must drop and rise again to freeze.
    lap = 1'b0;
    tick();
    check_now("lap_low", 8'hB0, 8'h24, 8'hF9, 8'hFF);
    lap = 1'b1;
    tick();
    check_now("relap_edge_cycle", 8'hB0, 8'h24, 8'hF9, 8'hFF);
    lap = 1'b0;
    d2 = 4'd9; d1 = 4'd9; d0 = 4'd9;
    scan("relap_frozen", 16, 8'hB0, 8'h24, 8'hF9, 8'hC7);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
`default_nettype wire
